// File: rtl/acc_norm_sequencer_pkg.sv
// Purpose: shared definitions for the accelerometer normalisation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default axis width and the sequencer state encoding, so the
// attitude-sensor top level and benches can decode the FSM state.

`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

package acc_norm_sequencer_pkg;

    // Default width of one signed fixed-point accelerometer axis.
    localparam int ACC_WIDTH_DFLT = `ACC_WIDTH;

    // Default watchdog budget for the WAIT_DONE state, in cycles.
    localparam int TIMEOUT_DFLT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_OUTPUT    = 3'd4
    } seq_state_t;

    // Width of the WAIT_DONE cycle counter (at least one bit).
    function automatic int tcnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/acc_norm_sequencer.sv
// Purpose: drives accVecNorm's level start/done handshake for one raw accel sample at a time.
// Latency: 1 cycle before the normaliser, 2 cycles after its done; zero vectors bypass in 1 cycle.
// Backpressure: s_ready only in IDLE; m_valid/m_data hold until m_ready, one sample in flight.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   s_valid/s_ready/s_data      raw sample stream, {z,y,x}, x in the LSBs
//   norm_start/norm_done        level-held handshake with accVecNorm
//   norm_data_in/norm_data_out  latched raw sample out, normalised vector in
//   m_valid/m_ready/m_data      result stream to the filter update stage
//   zero_vec                    one-cycle pulse when the zero-vector bypass is taken
//   timeout_err/err_clr         sticky watchdog flag and its clear
//   sample_cnt                  results delivered, wraps 0xFFFF -> 0

module acc_norm_sequencer
    import acc_norm_sequencer_pkg::*;
#(
    parameter int ACC_WIDTH      = acc_norm_sequencer_pkg::ACC_WIDTH_DFLT,
    parameter int TIMEOUT_CYCLES = acc_norm_sequencer_pkg::TIMEOUT_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [3*ACC_WIDTH-1:0] s_data,

    output logic                   norm_start,
    input  logic                   norm_done,
    output logic [3*ACC_WIDTH-1:0] norm_data_in,
    input  logic [3*ACC_WIDTH-1:0] norm_data_out,

    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [3*ACC_WIDTH-1:0] m_data,

    output logic                   zero_vec,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [15:0]            sample_cnt
);

    localparam int                TCNT_W    = tcnt_width(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        state;
    logic [TCNT_W-1:0] tcnt;
    // Remembers whether the normaliser finished (1) or the watchdog fired (0)
    // while RELEASE waits for done to drop.
    logic              ok;

    // Every output is a register written on state transitions, so nothing
    // combinational reaches an output from an input. norm_data_in doubles as
    // the sample register; m_data doubles as the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tcnt         <= '0;
            ok           <= 1'b0;
            s_ready      <= 1'b0;
            norm_start   <= 1'b0;
            norm_data_in <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            zero_vec     <= 1'b0;
            timeout_err  <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            zero_vec <= 1'b0;

            // A watchdog set later in this block overrides a same-cycle clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        norm_data_in <= s_data;
                        s_ready      <= 1'b0;
                        if (s_data == '0) begin
                            // Normalising a zero vector is undefined; pass zero straight out.
                            m_data   <= '0;
                            zero_vec <= 1'b1;
                            m_valid  <= 1'b1;
                            state    <= ST_OUTPUT;
                        end else begin
                            state <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    norm_start <= 1'b1;
                    tcnt       <= '0;
                    state      <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    tcnt <= tcnt + 1'b1;
                    if (norm_done) begin
                        // Done is checked first so it wins over a coincident timeout.
                        m_data     <= norm_data_out;
                        ok         <= 1'b1;
                        norm_start <= 1'b0;
                        state      <= ST_RELEASE;
                    end else if (tcnt == TCNT_LAST) begin
                        timeout_err <= 1'b1;
                        ok          <= 1'b0;
                        norm_start  <= 1'b0;
                        state       <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // Wait for the normaliser to return to idle before anything
                    // else can issue a new start. No watchdog here by design.
                    if (!norm_done) begin
                        if (ok) begin
                            m_valid <= 1'b1;
                            state   <= ST_OUTPUT;
                        end else begin
                            // Timed-out sample is dropped.
                            s_ready <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end

                ST_OUTPUT: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        sample_cnt <= sample_cnt + 16'd1;
                        s_ready    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    s_ready    <= 1'b0;
                    norm_start <= 1'b0;
                    m_valid    <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
